// File: rtl/imem_line_fetcher.sv
// Instruction line-fill engine: fetches four 32-bit SRAM words into one 128-bit cache line.
// Miss: 4 SRAM transfers + 1 cycle; hit in last-line buffer: 1 cycle. SRAM request held until ack.
// Backpressure: sram_ack stalls the fill; a dropped request drains the outstanding SRAM read first.
module imem_line_fetcher #(
    parameter logic BUF_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         imem_read_start,
    input  logic [31:0]  imemory_address_bus1,
    output logic [127:0] imemory_data_bus1,
    output logic         imem_read_rdy,
    output logic         sram_req,
    output logic [31:0]  sram_addr,
    input  logic         sram_ack,
    input  logic [31:0]  sram_rdata
);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

    state_t         state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [27:0]    tag_q, tag_d;
    logic           bv_q, bv_d;
    logic [127:0]   line_q, line_d;
    logic           req_q, req_d;
    logic [31:0]    addr_q, addr_d;
    logic           rdy_q, rdy_d;
    logic [1:0]     cnt_inc;
    logic           buf_hit;
    logic           unused_addr_bits;

    assign unused_addr_bits = ^imemory_address_bus1[3:0];
    assign cnt_inc          = cnt_q + 2'd1;
    assign buf_hit          = (BUF_EN != 1'b0) && bv_q && (imemory_address_bus1[31:4] == tag_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        bv_d    = bv_q;
        line_d  = line_q;
        req_d   = req_q;
        addr_d  = addr_q;
        rdy_d   = 1'b0;
        case (state_q)
            IDLE: begin
                req_d = 1'b0;
                if (imem_read_start) begin
                    if (buf_hit) begin
                        state_d = DONE;
                        rdy_d   = 1'b1;
                    end else begin
                        state_d = FILL;
                        tag_d   = imemory_address_bus1[31:4];
                        cnt_d   = 2'd0;
                        bv_d    = 1'b0;
                        req_d   = 1'b1;
                        addr_d  = {imemory_address_bus1[31:4], 4'b0000};
                    end
                end
            end
            FILL: begin
                if (imem_read_start) begin
                    if (sram_ack) begin
                        line_d[{cnt_q, 5'b00000} +: 32] = sram_rdata;
                        if (cnt_q == 2'd3) begin
                            bv_d    = 1'b1;
                            req_d   = 1'b0;
                            state_d = DONE;
                            rdy_d   = 1'b1;
                        end else begin
                            cnt_d  = cnt_inc;
                            addr_d = {tag_q, cnt_inc, 2'b00};
                        end
                    end
                end else if (sram_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    // The SRAM read already issued must complete before going idle.
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (sram_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            tag_q   <= 28'd0;
            bv_q    <= 1'b0;
            line_q  <= 128'd0;
            req_q   <= 1'b0;
            addr_q  <= 32'd0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            bv_q    <= bv_d;
            line_q  <= line_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            rdy_q   <= rdy_d;
        end
    end

    assign imemory_data_bus1 = line_q;
    assign imem_read_rdy     = rdy_q;
    assign sram_req          = req_q;
    assign sram_addr         = addr_q;

endmodule
